rf_wb_arbiter: RTL

//  Shares the single write port of the 32x32 register file between the pipeline
//  WB stage and the multi-cycle mul/div unit. Holds one mul/div result in a

---
 rtl/rf_wb_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between the WB stage and a one-entry
// mul/div result buffer, and tracks registers still waiting on a mul/div result.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_we,
    input  logic [4:0]    wb_wn,
    input  logic [DW-1:0] wb_wd,
    input  logic          md_valid,
    input  logic [4:0]    md_wn,
    input  logic [DW-1:0] md_wd,
    output logic          md_ready,
    input  logic          md_issue,
    input  logic [4:0]    md_issue_rn,
    input  logic [4:0]    rn1,
    input  logic [4:0]    rn2,
    output logic          hazard,
    output logic          stall_o,
    output logic          rf_we,
    output logic [4:0]    rf_wn,
    output logic [DW-1:0] rf_wd
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_HELD,
        S_FORCE
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [3:0]    r_cnt;
    logic [3:0]    w_nextCnt;
    logic [4:0]    r_bufWn;
    logic [DW-1:0] r_bufWd;
    logic [31:0]   r_busy;
    logic [31:0]   w_nextBusy;
    logic          w_wbEff;
    logic          w_capture;
    logic          w_clr;

    assign w_wbEff = wb_we && (wb_wn != 5'd0);
    assign hazard  = r_busy[rn1] | r_busy[rn2];

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        md_ready    = 1'b0;
        stall_o     = 1'b0;
        rf_we       = w_wbEff;
        rf_wn       = wb_wn;
        rf_wd       = wb_wd;
        w_capture   = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            S_EMPTY: begin
                md_ready = 1'b1;
                if (md_valid) begin
                    w_capture   = 1'b1;
                    w_nextState = S_HELD;
                end
            end
            S_HELD: begin
                // A buffered r0 result is dropped at once; WB keeps the port.
                if (r_bufWn == 5'd0) begin
                    w_nextState = S_EMPTY;
                    w_nextCnt   = 4'd0;
                end else if (!w_wbEff) begin
                    rf_we       = 1'b1;
                    rf_wn       = r_bufWn;
                    rf_wd       = r_bufWd;
                    w_clr       = 1'b1;
                    w_nextState = S_EMPTY;
                    w_nextCnt   = 4'd0;
                end else if (wb_wn == r_bufWn) begin
                    w_clr       = 1'b1;
                    w_nextState = S_EMPTY;
                    w_nextCnt   = 4'd0;
                end else begin
                    w_nextCnt = r_cnt + 4'd1;
                    if (r_cnt + 4'd1 == 4'(STARVE_LIMIT)) begin
                        w_nextState = S_FORCE;
                    end
                end
            end
            S_FORCE: begin
                rf_we       = (r_bufWn != 5'd0);
                rf_wn       = r_bufWn;
                rf_wd       = r_bufWd;
                stall_o     = 1'b1;
                w_clr       = 1'b1;
                w_nextState = S_EMPTY;
                w_nextCnt   = 4'd0;
            end
            default: begin
                w_nextState = S_EMPTY;
                w_nextCnt   = 4'd0;
            end
        endcase
    end

    // Set is applied after clear so a same-cycle reissue of r keeps it busy.
    always_comb begin
        w_nextBusy = r_busy;
        if (w_clr) begin
            w_nextBusy[r_bufWn] = 1'b0;
        end
        if (md_issue && (md_issue_rn != 5'd0)) begin
            w_nextBusy[md_issue_rn] = 1'b1;
        end
        w_nextBusy[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_cnt   <= 4'd0;
            r_bufWn <= 5'd0;
            r_bufWd <= '0;
            r_busy  <= 32'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_busy  <= w_nextBusy;
            if (w_capture) begin
                r_bufWn <= md_wn;
                r_bufWd <= md_wd;
            end
        end
    end

endmodule
